// File: rtl/fetch_branch_unit.sv
// Fetch/branch unit: a three-state sequencer (IDLE -> FETCH -> EXEC -> FETCH)
// that fetches one instruction word, presents it to the decoder for a single
// EXEC cycle, then updates pc, lr and the {N,Z,C,V} flag register.
module fetch_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [11:0] opcode,
  output logic        instr_valid,
  input  logic        branch,
  input  logic        beq,
  input  logic        bne,
  input  logic        bgt,
  input  logic        blt,
  input  logic        bge,
  input  logic        ble,
  input  logic        link,
  input  logic        ret,
  input  logic        flag_we,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_v,
  output logic [31:0] pc,
  output logic [31:0] lr,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_t;

  state_t state;
  logic   taken;
  logic   flag_n;
  logic   flag_z;
  logic   flag_v;

  // Branch target: pc + 8 plus the sign-extended 24-bit word offset.
  // Arithmetic wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] cur_pc,
                                                input logic [23:0] imm);
    logic signed [31:0] offset;
    offset = {{6{imm[23]}}, imm, 2'b00};
    return cur_pc + 32'd8 + offset;
  endfunction

  assign imem_addr = pc;
  assign opcode    = instr[31:20];
  assign flag_n    = flags[3];
  assign flag_z    = flags[2];
  assign flag_v    = flags[0];

  // Branch condition evaluated against the registered flags only, so a CMP
  // issued in the same EXEC cycle never affects this instruction's branch.
  always_comb begin
    taken = branch
          | (beq & flag_z)
          | (bne & ~flag_z)
          | (bgt & ~flag_z & (flag_n == flag_v))
          | (blt & (flag_n != flag_v))
          | (bge & (flag_n == flag_v))
          | (ble & (flag_z | (flag_n != flag_v)));
  end

  // Sequencer with registered outputs; pc/lr/flags/instr change only on the
  // FETCH->EXEC capture and at the EXEC edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 32'h0;
      pc          <= RESET_PC;
      lr          <= 32'h0;
      flags       <= 4'h0;
    end else begin
      case (state)
        S_IDLE: begin
          state       <= S_FETCH;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
        end
        S_FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            state       <= S_EXEC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          state       <= S_FETCH;
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
          if (taken && ret) begin
            pc <= lr;
          end else if (taken) begin
            pc <= branch_target(pc, instr[23:0]);
          end else begin
            pc <= pc + 32'd4;
          end
          if (taken && link) begin
            lr <= pc + 32'd4;
          end
          if (flag_we) begin
            flags <= {alu_n, alu_z, alu_c, alu_v};
          end
        end
        default: begin
          state       <= S_IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
